// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One shift-add / restoring shift-subtract step per cycle on operand magnitudes, then a sign-fix cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] hi_wdata,
    input  logic [WIDTH-1:0] lo_wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div, r_neg_q, r_neg_r, r_dz;
    logic [WIDTH-1:0] r_b, r_ph, r_pl;

    logic             w_signed, w_dz;
    logic [WIDTH-1:0] w_amag, w_bmag;
    logic [WIDTH:0]   w_sum, w_shift, w_diff;
    logic [WIDTH-1:0] w_ph_nx, w_pl_nx;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;
    logic [WIDTH-1:0] w_q, w_r;

    assign w_signed = ~op[0];
    assign w_dz     = op[1] && (opb == '0);
    assign w_amag   = (w_signed && opa[WIDTH-1]) ? -opa : opa;
    assign w_bmag   = (w_signed && opb[WIDTH-1]) ? -opb : opb;

    // Multiply: {carry, ph, pl} accumulates the product while pl shifts the multiplier out.
    assign w_sum   = {1'b0, r_ph} + {1'b0, (r_pl[0] ? r_b : '0)};
    // Divide: ph holds the partial remainder, pl shifts dividend bits out and quotient bits in.
    assign w_shift = {r_ph, r_pl[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_b};

    always_comb begin
        w_ph_nx = w_sum[WIDTH:1];
        w_pl_nx = {w_sum[0], r_pl[WIDTH-1:1]};
        if (r_is_div) begin
            if (!w_diff[WIDTH]) begin
                w_ph_nx = w_diff[WIDTH-1:0];
                w_pl_nx = {r_pl[WIDTH-2:0], 1'b1};
            end else begin
                w_ph_nx = w_shift[WIDTH-1:0];
                w_pl_nx = {r_pl[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign w_prod     = {r_ph, r_pl};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_q        = r_neg_q ? -r_pl : r_pl;
    assign w_r        = r_neg_r ? -r_ph : r_ph;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = w_dz ? S_FIX : S_CALC;
            S_CALC:  if (r_cnt == CW'(WIDTH-1)) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_b      <= '0;
            r_ph     <= '0;
            r_pl     <= '0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_div <= op[1];
                        r_neg_q  <= w_signed & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                        r_neg_r  <= w_signed & opa[WIDTH-1];
                        r_dz     <= w_dz;
                        div_zero <= w_dz;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        r_ph     <= w_dz ? opa : '0;
                        if (w_dz) begin
                            r_pl <= '1;
                            r_b  <= '0;
                        end else if (op[1]) begin
                            r_pl <= w_amag;
                            r_b  <= w_bmag;
                        end else begin
                            r_pl <= w_bmag;
                            r_b  <= w_amag;
                        end
                    end else begin
                        // Moves to HI/LO only land when no operation is being launched.
                        if (mthi) hi <= hi_wdata;
                        if (mtlo) lo <= lo_wdata;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_ph  <= w_ph_nx;
                    r_pl  <= w_pl_nx;
                end
                S_FIX: begin
                    r_cnt <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (r_dz) begin
                        hi <= r_ph;
                        lo <= r_pl;
                    end else if (r_is_div) begin
                        hi <= w_r;
                        lo <= w_q;
                    end else begin
                        {hi, lo} <= w_prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO/div_zero, a monitor checks them on done.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0, rst = 1'b1, start = 1'b0, mthi = 1'b0, mtlo = 1'b0;
    logic [1:0]   op = '0;
    logic [W-1:0] opa = '0, opb = '0, hi_wdata = '0, lo_wdata = '0;
    logic [W-1:0] hi, lo;
    logic         busy, done, div_zero;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
        .mthi(mthi), .mtlo(mtlo), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0, failures = 0, done_cnt = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 expected=0");
            end else begin
                e = sb.pop_front();
                chk("sb_hi", hi, e.hi);
                chk("sb_lo", lo, e.lo);
                chk("sb_div_zero", {31'd0, div_zero}, {31'd0, e.dz});
            end
        end
    end

    task automatic do_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                         input logic edz, input int ecyc, input logic with_mtlo, input logic interfere);
        exp_t e;
        int   cyc;
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        mtlo = with_mtlo; lo_wdata = 32'hDEADBEEF;
        e.hi = ehi; e.lo = elo; e.dz = edz;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0; mtlo = 1'b0;
        opa = 32'h13579BDF; opb = '0;
        chk({name, "_lo_hold"}, lo, m_lo);
        cyc = 0;
        while (busy && cyc < 50) begin
            cyc++;
            if (interfere && cyc == 5) begin
                start = 1'b1; op = 2'b01; opa = 32'h7; opb = 32'h9;
                mthi = 1'b1; hi_wdata = 32'hAAAA5555;
            end
            if (interfere && cyc == 7) begin
                chk({name, "_hi_hold"}, hi, m_hi);
                start = 1'b0; mthi = 1'b0;
            end
            @(negedge clk);
        end
        chk({name, "_busy_cycles"}, 32'(cyc), 32'(ecyc));
        m_hi = ehi;
        m_lo = elo;
        @(negedge clk);
        chk({name, "_drained"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_div_zero", {31'd0, div_zero}, 32'd0);

        mthi = 1'b1; hi_wdata = 32'h12345678;
        @(negedge clk);
        mthi = 1'b0;
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_lo", lo, 32'h0);
        m_hi = 32'h12345678;

        do_op("mult_neg3x7",  2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 1'b0, 1'b0);
        do_op("multu_max",    2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 1'b0, 1'b0);
        do_op("div_neg7by2",  2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 1'b0, 1'b0);
        do_op("divu_100by7",  2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 1'b0, 1'b0);
        do_op("div_minbym1",  2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 33, 1'b0, 1'b0);
        do_op("divu_by0",     2'b11, 32'h55, 32'h0, 32'h55, 32'hFFFFFFFF, 1'b1, 1, 1'b0, 1'b0);
        chk("dz_sticky", {31'd0, div_zero}, 32'd1);
        do_op("multu_mtlo",   2'b01, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0, 33, 1'b1, 1'b0);
        chk("dz_cleared", {31'd0, div_zero}, 32'd0);
        do_op("mult_interf",  2'b00, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h0, 32'd30, 1'b0, 33, 1'b0, 1'b1);

        // Abort a long operation partway through; no result may be produced.
        @(negedge clk);
        start = 1'b1; op = 2'b01; opa = 32'hFFFFFFFF; opb = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        dc = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt), 32'(dc));
        m_hi = '0;
        m_lo = '0;

        do_op("div_7bym2",    2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 33, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
